// File: rtl/digit_to_seg.sv
// Eight-digit time-multiplexed seven-segment driver for a common-anode display.
// Scans eight hex nibbles onto a shared active-low segment bus, DWELL cycles per digit.
module digit_to_seg #(
    parameter int DWELL = 1024
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] in4,
    input  logic [3:0] in5,
    input  logic [3:0] in6,
    input  logic [3:0] in7,
    input  logic [3:0] in8,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_dwell;
    logic [2:0]    r_index;
    logic [3:0]    w_nibble;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            4'hF:    hex_to_seg = 7'h0E;
            default: hex_to_seg = 7'h7F;
        endcase
    endfunction

    // Select the live nibble for the digit currently being scanned
    always_comb begin
        w_nibble = in1;
        case (r_index)
            3'd0:    w_nibble = in1;
            3'd1:    w_nibble = in2;
            3'd2:    w_nibble = in3;
            3'd3:    w_nibble = in4;
            3'd4:    w_nibble = in5;
            3'd5:    w_nibble = in6;
            3'd6:    w_nibble = in7;
            3'd7:    w_nibble = in8;
            default: w_nibble = in1;
        endcase
    end

    // Dwell counter and digit index; index steps when the counter wraps
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_dwell <= '0;
            r_index <= 3'd0;
        end else if (r_dwell == LAST) begin
            r_dwell <= '0;
            r_index <= r_index + 3'd1;
        end else begin
            r_dwell <= r_dwell + CW'(1);
            r_index <= r_index;
        end
    end

    // Registered outputs: anode and segments switch together, so no ghosting
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(8'h01 << r_index);
            r_seg <= hex_to_seg(w_nibble);
            r_dp  <= 1'b1;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_digit_to_seg.sv
// Directed bench for digit_to_seg: a cycle model pushes expected outputs to a
// queue before each edge; they are popped and compared just after the edge.
module tb_digit_to_seg;

    localparam int DW = 64;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       mclk = 1'b0;
    logic       rst  = 1'b0;
    logic [3:0] in1 = 4'h0, in2 = 4'h0, in3 = 4'h0, in4 = 4'h0;
    logic [3:0] in5 = 4'h0, in6 = 4'h0, in7 = 4'h0, in8 = 4'h0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;
    int   m_idx = 0;
    exp_t q[$];

    logic [7:0] an_tab [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    digit_to_seg #(.DWELL(DW)) dut (
        .mclk(mclk), .rst(rst),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in5(in5), .in6(in6), .in7(in7), .in8(in8),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] tb_in(input int k);
        case (k)
            0:       return in1;
            1:       return in2;
            2:       return in3;
            3:       return in4;
            4:       return in5;
            5:       return in6;
            6:       return in7;
            default: return in8;
        endcase
    endfunction

    task automatic set_all(input logic [3:0] v);
        in1 = v; in2 = v; in3 = v; in4 = v; in5 = v; in6 = v; in7 = v; in8 = v;
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step();
        exp_t e;
        exp_t g;
        e.an  = an_tab[m_idx];
        e.seg = seg_tab[tb_in(m_idx)];
        e.dp  = 1'b1;
        q.push_back(e);
        if (m_cnt == DW - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 8;
        end else begin
            m_cnt = m_cnt + 1;
        end
        @(posedge mclk);
        #1;
        g = q.pop_front();
        check("an", an, g.an);
        check("seg", {1'b0, seg}, {1'b0, g.seg});
        check("dp", {7'd0, dp}, {7'd0, g.dp});
        check("onehot", 8'($countones(~an)), 8'd1);
        @(negedge mclk);
    endtask

    initial begin
        // Reset applies without any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_an", an, 8'hFF);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_dp", {7'd0, dp}, 8'h01);
        repeat (5) @(posedge mclk);
        #1;
        check("rst_hold_an", an, 8'hFF);

        // Scan pattern A,b,C,d,1,2,3,4 over three full scans
        in1 = 4'hA; in2 = 4'hB; in3 = 4'hC; in4 = 4'hD;
        in5 = 4'h1; in6 = 4'h2; in7 = 4'h3; in8 = 4'h4;
        @(negedge mclk);
        rst = 1'b0;
        m_cnt = 0;
        m_idx = 0;
        step();
        check("first_an", an, 8'hFE);
        check("first_seg", {1'b0, seg}, 8'h08);
        repeat (3 * 8 * DW - 1) step();

        // Decode sweep: every value on every digit
        for (int v = 0; v < 16; v++) begin
            set_all(4'(v));
            repeat (8 * DW) step();
        end

        // Live update on the selected digit
        set_all(4'h0);
        step();
        step();
        check("live_pre_an", an, 8'hFE);
        check("live_pre_seg", {1'b0, seg}, 8'h40);
        in1 = 4'h5;
        step();
        check("live_post_an", an, 8'hFE);
        check("live_post_seg", {1'b0, seg}, 8'h12);

        // Reset in the middle of digit 5
        for (int i = 0; i < 8 * DW && !(m_idx == 5 && m_cnt == 10); i++) step();
        check("pre_rst_an", an, 8'hDF);
        rst = 1'b1;
        #1;
        check("mid_rst_an", an, 8'hFF);
        check("mid_rst_seg", {1'b0, seg}, 8'h7F);
        repeat (3) @(negedge mclk);
        check("mid_rst_hold_an", an, 8'hFF);
        rst = 1'b0;
        m_cnt = 0;
        m_idx = 0;
        repeat (DW) step();
        check("restart_last_an", an, 8'hFE);
        step();
        check("restart_next_an", an, 8'hFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
